tile_map_ctrl: RTL and testbench

- Controller for the 4x4 sliding-tile puzzle mapping used by the VGA pixel path.
- Holds a 16-entry permutation table: screen tile position -> source tile index. Tile 15 is the blank.
- Decodes the 4-bit instruction/set command interface to clear, scramble or move tiles.
- Serves a registered lookup port to the display datapath and reports busy, solved and move count.

---
 rtl/tile_pkg.sv | 69 ++++++
 rtl/tile_map_ctrl_if.sv | 25 ++
 rtl/tile_lfsr16.sv | 27 ++
 rtl/tile_map_ctrl.sv | 147 ++++++++++++++
 tb/tb_tile_map_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the 4x4 sliding-tile map controller.
// Latency: none (constants, types and pure combinational helpers).
// Backpressure: not applicable.
package tile_pkg;

   localparam int         GRID_DIM   = 4;
   localparam logic [1:0] GRID_MAX   = 2'(GRID_DIM - 1);
   localparam logic [3:0] BLANK_TILE = 4'd15;

   // Opcodes; the low two bits of the move opcodes double as the direction code.
   localparam logic [3:0] OP_NOP      = 4'd0;
   localparam logic [3:0] OP_CLEAR    = 4'd1;
   localparam logic [3:0] OP_SCRAMBLE = 4'd2;
   localparam logic [3:0] OP_UP       = 4'd4;
   localparam logic [3:0] OP_DOWN     = 4'd5;
   localparam logic [3:0] OP_LEFT     = 4'd6;
   localparam logic [3:0] OP_RIGHT    = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SCRAMBLE,
      ST_MOVE,
      ST_CHECK
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   typedef struct packed {
      logic       legal;
      logic [3:0] target;
   } nbr_t;

   function automatic logic is_valid_op(input logic [3:0] op);
      logic ok;
      case (op)
         OP_NOP:                             ok = 1'b0;
         OP_CLEAR, OP_SCRAMBLE:              ok = 1'b1;
         OP_UP, OP_DOWN, OP_LEFT, OP_RIGHT:  ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Neighbour of a {row,col} position in the given direction; legal=0 off-grid.
   function automatic nbr_t neighbour(input logic [3:0] pos, input dir_t dir);
      nbr_t       n;
      logic [1:0] row;
      logic [1:0] col;
      row      = pos[3:2];
      col      = pos[1:0];
      n.legal  = 1'b0;
      n.target = pos;
      case (dir)
         DIR_UP:    if (row != 2'd0)    begin n.legal = 1'b1; n.target = {row - 2'd1, col}; end
         DIR_DOWN:  if (row != GRID_MAX) begin n.legal = 1'b1; n.target = {row + 2'd1, col}; end
         DIR_LEFT:  if (col != 2'd0)    begin n.legal = 1'b1; n.target = {row, col - 2'd1}; end
         DIR_RIGHT: if (col != GRID_MAX) begin n.legal = 1'b1; n.target = {row, col + 2'd1}; end
         default:   n.legal = 1'b0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tile_map_ctrl_if.sv
// Command/lookup/status bundle between the board/display side and tile_map_ctrl.
// Latency: none (wires only).
// Backpressure: none; busy tells the issuer that further set edges are dropped.
// Ports: instruction/set command, rd_pos lookup in; rd_src, blank_pos, busy,
//        solved, move_count out of the controller.
interface tile_map_ctrl_if;
   logic [3:0] instruction;
   logic       set;
   logic [3:0] rd_pos;
   logic [3:0] rd_src;
   logic [3:0] blank_pos;
   logic       busy;
   logic       solved;
   logic [9:0] move_count;

   modport master (
      output instruction, set, rd_pos,
      input  rd_src, blank_pos, busy, solved, move_count
   );

   modport slave (
      input  instruction, set, rd_pos,
      output rd_src, blank_pos, busy, solved, move_count
   );
endinterface

// File: rtl/tile_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (shift left, taps 15,13,12,10).
// Latency: advances every clock, including while the controller is idle.
// Backpressure: none.
// Ports: i_clk, i_rst (sync, active high, loads SEED), o_lfsr current state.
module tile_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [15:0] o_lfsr
);

   logic [15:0] r_lfsr;
   logic        w_fb;

   assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign o_lfsr = r_lfsr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lfsr <= SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
      end
   end

endmodule

// File: rtl/tile_map_ctrl.sv
// 4x4 sliding-tile permutation table with clear/scramble/move commands.
// Latency: rd_src 1 cycle; set edge to busy low: move 18, clear 33, scramble SCRAMBLE_MOVES+17.
// Backpressure: none; set edges arriving while busy are dropped, not queued.
// Ports: sysclk, reset (sync, active high), bus (slave side of tile_map_ctrl_if).
module tile_map_ctrl #(
   parameter int          SCRAMBLE_MOVES = 64,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic            sysclk,
   input  logic            reset,
   tile_map_ctrl_if.slave  bus
);
   import tile_pkg::*;

   logic [3:0]  r_map [16];
   logic [3:0]  r_blank;
   logic [3:0]  r_rd_src;
   logic        r_busy;
   logic        r_solved;
   logic [9:0]  r_move_cnt;
   logic        r_set_q;
   state_t      r_state;
   logic [9:0]  r_cnt;
   dir_t        r_dir;
   logic        r_acc;

   state_t      w_next_state;
   logic        w_edge;
   logic        w_accept;
   dir_t        w_dir_sel;
   nbr_t        w_nbr;
   logic        w_last16;
   logic        w_scr_last;
   logic        w_chk_ok;
   logic        w_acc_in;
   logic [15:0] w_lfsr;
   logic        w_unused_lfsr;

   tile_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .i_clk  (sysclk),
      .i_rst  (reset),
      .o_lfsr (w_lfsr)
   );

   assign w_unused_lfsr = ^w_lfsr[15:2];

   assign bus.rd_src     = r_rd_src;
   assign bus.blank_pos  = r_blank;
   assign bus.busy       = r_busy;
   assign bus.solved     = r_solved;
   assign bus.move_count = r_move_cnt;

   always_comb begin
      w_edge = bus.set & ~r_set_q;
      // r_busy trails the state by one cycle, so it also guards the cycle
      // right after CHECK returns to IDLE.
      w_accept   = w_edge && (r_state == ST_IDLE) && !r_busy && is_valid_op(bus.instruction);
      // Scramble draws its direction from the LFSR; a user move uses the latched one.
      w_dir_sel  = (r_state == ST_SCRAMBLE) ? dir_t'(w_lfsr[1:0]) : r_dir;
      w_nbr      = neighbour(r_blank, w_dir_sel);
      w_last16   = (r_cnt[3:0] == 4'd15);
      w_scr_last = (r_cnt == 10'(SCRAMBLE_MOVES - 1));
      w_chk_ok   = (r_map[r_cnt[3:0]] == r_cnt[3:0]);
      w_acc_in   = (r_cnt == 10'd0) ? 1'b1 : r_acc;

      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (bus.instruction)
                  OP_CLEAR:    w_next_state = ST_CLEAR;
                  OP_SCRAMBLE: w_next_state = ST_SCRAMBLE;
                  default:     w_next_state = ST_MOVE;
               endcase
            end
         end
         ST_CLEAR:    if (w_last16)   w_next_state = ST_CHECK;
         ST_SCRAMBLE: if (w_scr_last) w_next_state = ST_CHECK;
         ST_MOVE:     w_next_state = ST_CHECK;
         ST_CHECK:    if (w_last16)   w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) r_map[i] <= 4'(i);
         r_blank    <= BLANK_TILE;
         r_rd_src   <= 4'd0;
         r_busy     <= 1'b0;
         r_solved   <= 1'b1;
         r_move_cnt <= 10'd0;
         r_set_q    <= 1'b0;
         r_state    <= ST_IDLE;
         r_cnt      <= 10'd0;
         r_dir      <= DIR_UP;
         r_acc      <= 1'b1;
      end else begin
         r_set_q  <= bus.set;
         r_state  <= w_next_state;
         r_busy   <= (r_state != ST_IDLE);
         // Reads the pre-swap contents when a swap lands in the same cycle.
         r_rd_src <= r_map[bus.rd_pos];

         // Per-state cycle index restarts on every state change.
         if (w_next_state != r_state) begin
            r_cnt <= 10'd0;
         end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 10'd1;
         end

         if (w_accept) r_dir <= dir_t'(bus.instruction[1:0]);

         case (r_state)
            ST_CLEAR: begin
               r_map[r_cnt[3:0]] <= r_cnt[3:0];
               if (w_last16) begin
                  r_blank    <= BLANK_TILE;
                  r_move_cnt <= 10'd0;
               end
            end
            ST_SCRAMBLE: begin
               if (w_nbr.legal) begin
                  r_map[r_blank]      <= r_map[w_nbr.target];
                  r_map[w_nbr.target] <= r_map[r_blank];
                  r_blank             <= w_nbr.target;
               end
               if (w_scr_last) r_move_cnt <= 10'd0;
            end
            ST_MOVE: begin
               if (w_nbr.legal) begin
                  r_map[r_blank]      <= r_map[w_nbr.target];
                  r_map[w_nbr.target] <= r_map[r_blank];
                  r_blank             <= w_nbr.target;
                  if (r_move_cnt != 10'h3FF) r_move_cnt <= r_move_cnt + 10'd1;
               end
            end
            ST_CHECK: begin
               r_acc <= w_acc_in & w_chk_ok;
               if (w_last16) r_solved <= w_acc_in & w_chk_ok;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Self-checking bench for tile_map_ctrl: table-driven lookups and commands plus
// hand-written scramble, dropped-edge and mid-scramble reset sequences.
// Latency/backpressure: drives one command at a time and waits for busy to fall.
module tb_tile_map_ctrl;
   import tile_pkg::*;

   localparam int          M    = 64;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk;
   logic rst;
   tile_map_ctrl_if bus ();

   tile_map_ctrl #(.SCRAMBLE_MOVES(M), .LFSR_SEED(SEED)) dut (
      .sysclk (clk),
      .reset  (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] rd_pos;
      logic [3:0] exp_src;
   } rd_vec_t;

   typedef struct {
      logic [3:0] op;
      int         exp_lat;
      logic [3:0] exp_blank;
      int         exp_mc;
      logic       exp_solved;
   } cmd_vec_t;

   int          n_checks;
   int          n_err;
   logic [3:0]  rd_map [16];
   logic [3:0]  mm [16];
   logic [15:0] m_lfsr;
   logic [15:0] snap;

   function automatic logic [15:0] step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Independent LFSR model, reset alongside the DUT.
   always @(posedge clk) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= step(m_lfsr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.set = 1'b0;
      bus.instruction = OP_NOP;
      bus.rd_pos = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic read_map();
      for (int p = 0; p < 16; p++) begin
         bus.rd_pos = 4'(p);
         @(posedge clk);
         #1 rd_map[p] = bus.rd_src;
      end
   endtask

   // Issue one command; returns cycles from the accepting edge to busy low
   // (0 if busy never rose, -1 on timeout). Optionally pulses set mid-run.
   task automatic issue(input logic [3:0] op, input int pulse_at, input logic [3:0] pulse_op,
                        output int lat);
      bit rose;
      bus.instruction = op;
      bus.set = 1'b1;
      @(posedge clk);
      #1;
      snap = m_lfsr;
      bus.set = 1'b0;
      rose = 0;
      lat = -1;
      for (int n = 1; n <= 2000; n++) begin
         @(posedge clk);
         #1;
         if (bus.busy) rose = 1;
         if (pulse_at != 0 && n == pulse_at) begin
            bus.instruction = pulse_op;
            bus.set = 1'b1;
         end
         if (pulse_at != 0 && n == pulse_at + 1) bus.set = 1'b0;
         if (rose && !bus.busy) begin lat = n; break; end
         if (!rose && n == 25) begin lat = 0; break; end
      end
      if (lat < 0) $display("FAIL busy_timeout: got busy stuck expected release");
   endtask

   task automatic check_identity_except_up(input string name, input bit up_applied);
      int bad;
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         logic [3:0] e;
         e = 4'(k);
         if (up_applied && k == 11) e = 4'd15;
         if (up_applied && k == 15) e = 4'd11;
         if (rd_map[k] !== e) bad++;
      end
      chk(name, bad, 0);
   endtask

   task automatic up_scenario(input string tag);
      int lat;
      issue(OP_UP, 0, OP_NOP, lat);
      chk({tag, "_lat"}, lat, 18);
      chk({tag, "_blank"}, bus.blank_pos, 11);
      chk({tag, "_mc"}, bus.move_count, 1);
      chk({tag, "_solved"}, bus.solved, 0);
      read_map();
      chk({tag, "_map11"}, rd_map[11], 15);
      chk({tag, "_map15"}, rd_map[15], 11);
      check_identity_except_up({tag, "_map_rest"}, 1);
   endtask

   rd_vec_t  rdv  [16];
   cmd_vec_t cmds [15];

   initial begin
      int lat;
      n_checks = 0;
      n_err = 0;

      for (int i = 0; i < 16; i++) rdv[i] = '{rd_pos: 4'(i), exp_src: 4'(i)};
      cmds[0]  = '{OP_DOWN,     18, 4'd15, 0, 1'b1};
      cmds[1]  = '{OP_RIGHT,    18, 4'd15, 0, 1'b1};
      cmds[2]  = '{OP_NOP,       0, 4'd15, 0, 1'b1};
      cmds[3]  = '{4'd3,         0, 4'd15, 0, 1'b1};
      cmds[4]  = '{OP_UP,       18, 4'd11, 1, 1'b0};
      cmds[5]  = '{OP_LEFT,     18, 4'd10, 2, 1'b0};
      cmds[6]  = '{OP_UP,       18, 4'd6,  3, 1'b0};
      cmds[7]  = '{OP_UP,       18, 4'd2,  4, 1'b0};
      cmds[8]  = '{OP_UP,       18, 4'd2,  4, 1'b0};
      cmds[9]  = '{OP_DOWN,     18, 4'd6,  5, 1'b0};
      cmds[10] = '{OP_DOWN,     18, 4'd10, 6, 1'b0};
      cmds[11] = '{OP_RIGHT,    18, 4'd11, 7, 1'b0};
      cmds[12] = '{OP_DOWN,     18, 4'd15, 8, 1'b1};
      cmds[13] = '{4'hB,         0, 4'd15, 8, 1'b1};
      cmds[14] = '{OP_CLEAR,    33, 4'd15, 0, 1'b1};

      // Reset state and lookup sweep.
      do_reset();
      chk("rst_busy", bus.busy, 0);
      chk("rst_solved", bus.solved, 1);
      chk("rst_blank", bus.blank_pos, 15);
      chk("rst_mc", bus.move_count, 0);
      chk("rst_rd_src", bus.rd_src, 0);
      for (int i = 0; i < 16; i++) begin
         bus.rd_pos = rdv[i].rd_pos;
         @(posedge clk);
         #1 chk($sformatf("rd_src[%0d]", i), bus.rd_src, rdv[i].exp_src);
      end

      // Single legal UP from reset.
      up_scenario("up");

      // Command table from a fresh reset.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         issue(cmds[i].op, 0, OP_NOP, lat);
         chk($sformatf("cmd%0d_lat", i), lat, cmds[i].exp_lat);
         chk($sformatf("cmd%0d_blank", i), bus.blank_pos, cmds[i].exp_blank);
         chk($sformatf("cmd%0d_mc", i), bus.move_count, cmds[i].exp_mc);
         chk($sformatf("cmd%0d_solved", i), bus.solved, cmds[i].exp_solved);
      end
      read_map();
      check_identity_except_up("cmd_map", 0);

      // Scramble with a dropped set edge mid-run, checked against the model.
      do_reset();
      issue(OP_SCRAMBLE, 10, OP_UP, lat);
      chk("scr_lat", lat, M + 17);
      begin
         logic [3:0]  b;
         logic [15:0] s;
         logic [15:0] seen;
         int          bad;
         logic        pred_solved;
         for (int k = 0; k < 16; k++) mm[k] = 4'(k);
         b = 4'd15;
         s = snap;
         for (int k = 0; k < M; k++) begin
            logic [1:0] r;
            logic [1:0] c;
            logic [3:0] t;
            logic       ok;
            logic [3:0] tmp;
            r = b[3:2];
            c = b[1:0];
            ok = 1'b0;
            t = b;
            case (s[1:0])
               2'b00: if (r != 2'd0) begin ok = 1'b1; t = {r - 2'd1, c}; end
               2'b01: if (r != 2'd3) begin ok = 1'b1; t = {r + 2'd1, c}; end
               2'b10: if (c != 2'd0) begin ok = 1'b1; t = {r, c - 2'd1}; end
               default: if (c != 2'd3) begin ok = 1'b1; t = {r, c + 2'd1}; end
            endcase
            if (ok) begin
               tmp = mm[b]; mm[b] = mm[t]; mm[t] = tmp; b = t;
            end
            s = step(s);
         end
         pred_solved = 1'b1;
         for (int k = 0; k < 16; k++) if (mm[k] != 4'(k)) pred_solved = 1'b0;
         chk("scr_blank", bus.blank_pos, b);
         chk("scr_mc", bus.move_count, 0);
         chk("scr_solved", bus.solved, pred_solved);
         read_map();
         seen = '0;
         bad = 0;
         for (int k = 0; k < 16; k++) begin
            seen[rd_map[k]] = 1'b1;
            if (rd_map[k] !== mm[k]) bad++;
         end
         chk("scr_perm", seen, 16'hFFFF);
         chk("scr_map_model", bad, 0);
         chk("scr_blank_tile", rd_map[b], 15);
      end

      // Clear after scramble.
      issue(OP_CLEAR, 0, OP_NOP, lat);
      chk("clr_lat", lat, 33);
      chk("clr_blank", bus.blank_pos, 15);
      chk("clr_mc", bus.move_count, 0);
      chk("clr_solved", bus.solved, 1);
      read_map();
      check_identity_except_up("clr_map", 0);

      // Reset in the middle of a scramble.
      bus.instruction = OP_SCRAMBLE;
      bus.set = 1'b1;
      @(posedge clk);
      #1 bus.set = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("mid_busy_before", bus.busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_busy", bus.busy, 0);
      chk("mid_lfsr", dut.u_lfsr.o_lfsr, SEED);
      chk("mid_blank", bus.blank_pos, 15);
      chk("mid_mc", bus.move_count, 0);
      rst = 1'b0;
      read_map();
      check_identity_except_up("mid_map", 0);
      up_scenario("mid_up");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
